// File: rtl/run_launcher_if.sv
// Signal bundle between run_launcher (master) and the board inputs / cycle-count controller (slave).
interface run_launcher_if #(
  parameter int CW = 11
);
  // go is a level whose rising edge requests a run. start is a single-cycle
  // pulse, and done then stays high until ctrl_clear. clock_count is valid
  // whenever done=1. There is no ready/backpressure path.
  logic          go;
  logic          done;
  logic [CW-1:0] clock_count;
  logic          ctrl_clear;
  logic          start;
  logic          busy;
  logic          result_valid;
  logic [CW-1:0] result_count;
  logic          timeout;
  logic [7:0]    run_count;
  logic          mismatch;

  modport master (
    input  go, done, clock_count,
    output ctrl_clear, start, busy, result_valid, result_count,
           timeout, run_count, mismatch
  );

  modport slave (
    output go, done, clock_count,
    input  ctrl_clear, start, busy, result_valid, result_count,
           timeout, run_count, mismatch
  );
endinterface

// File: rtl/run_launcher.sv
// Clears the cycle-count controller, pulses start, waits for done under a watchdog, captures the count.
// Optional expected-count check is built only when RUN_LAUNCHER_CHECK_EN is defined.
module run_launcher #(
  parameter int CW           = 11,
  parameter int CLEAR_CYCLES = 2,
  parameter int TIMEOUT      = 2047
`ifdef RUN_LAUNCHER_CHECK_EN
  ,
  parameter int EXPECT_COUNT = 74
`endif
) (
  input  logic               clk,
  input  logic               reset,
  run_launcher_if.master     bus,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    LAUNCH = 2'd2,
    WAIT   = 2'd3
  } state_e;

  localparam logic [3:0]  CLR_LAST = 4'(CLEAR_CYCLES - 1);
  localparam logic [11:0] WD_LAST  = 12'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [3:0]    clr_cnt_q, clr_cnt_d;
  logic [11:0]   wd_q, wd_d;
  logic          go_q;
  logic          go_edge;
  logic          accept, capture, abort;

  logic          ctrl_clear_q, ctrl_clear_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          result_valid_q, result_valid_d;
  logic [CW-1:0] result_count_q, result_count_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    run_count_q, run_count_d;

  assign go_edge = bus.go & ~go_q;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wd_d      = wd_q;
    accept    = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    case (state_q)
      IDLE: begin
        clr_cnt_d = '0;
        if (go_edge) begin
          accept  = 1'b1;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 4'd1;
        if (clr_cnt_q == CLR_LAST) state_d = LAUNCH;
      end
      LAUNCH: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // done wins over the watchdog when both land in the same cycle
        if (bus.done) begin
          capture = 1'b1;
          state_d = IDLE;
        end else if (wd_q == WD_LAST) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 12'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    ctrl_clear_d   = (state_d == CLEAR) | abort;
    start_d        = (state_d == LAUNCH);
    busy_d         = (state_d != IDLE);
    result_valid_d = accept ? 1'b0 : (capture ? 1'b1 : result_valid_q);
    timeout_d      = accept ? 1'b0 : (abort ? 1'b1 : timeout_q);
    result_count_d = capture ? bus.clock_count : result_count_q;
    run_count_d    = capture ? run_count_q + 8'd1 : run_count_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      clr_cnt_q      <= '0;
      wd_q           <= '0;
      go_q           <= 1'b1;
      ctrl_clear_q   <= 1'b0;
      start_q        <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_count_q <= '0;
      timeout_q      <= 1'b0;
      run_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      clr_cnt_q      <= clr_cnt_d;
      wd_q           <= wd_d;
      go_q           <= bus.go;
      ctrl_clear_q   <= ctrl_clear_d;
      start_q        <= start_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      result_count_q <= result_count_d;
      timeout_q      <= timeout_d;
      run_count_q    <= run_count_d;
    end
  end

`ifdef RUN_LAUNCHER_CHECK_EN
  localparam logic [CW-1:0] EXP_C = CW'(EXPECT_COUNT);
  logic mismatch_q, mismatch_d;

  always_comb begin
    mismatch_d = mismatch_q;
    if (accept)       mismatch_d = 1'b0;
    else if (capture) mismatch_d = (bus.clock_count != EXP_C);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mismatch_q <= 1'b0;
    else        mismatch_q <= mismatch_d;
  end

  assign bus.mismatch = mismatch_q;
`else
  assign bus.mismatch = 1'b0;
`endif

  assign bus.ctrl_clear   = ctrl_clear_q;
  assign bus.start        = start_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_count = result_count_q;
  assign bus.timeout      = timeout_q;
  assign bus.run_count    = run_count_q;
  assign state_o          = state_q;

endmodule

// File: doc/run_launcher.md
# run_launcher

Sequencer that drives the cycle-count control FSM from the other side of its start/done interface. On a user `go` edge it clears the controller, issues a one-cycle `start`, waits for `done` under a watchdog, and captures the reported 11-bit cycle count. It also keeps a completed-run counter. It sits between board-level inputs (push-button/switch sync logic) and the controller, so each press re-arms a fresh run.

## Interface
Parameters:
- `CW`, 11: width of controller cycle count.
- `CLEAR_CYCLES`, 2: cycles `ctrl_clear` is held high before launch; legal range 1..15.
- `TIMEOUT`, 2047: maximum WAIT cycles before abort; legal range 1..4095. The watchdog is 12 bits.
- `EXPECT_COUNT`, 74: expected cycle count; used only with `RUN_LAUNCHER_CHECK_EN`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `go`, in, 1: run request, already synchronized; a rising edge launches a run.
- `done`, in, 1: completion flag from the controller; sticky high until the controller is cleared.
- `clock_count`, in, CW: cycle count from the controller; valid when `done`=1.
- `ctrl_clear`, out, 1: active-high synchronous clear to the controller.
- `start`, out, 1: one-cycle start pulse to the controller.
- `busy`, out, 1: high in every state except IDLE.
- `result_valid`, out, 1: `result_count` holds a captured count.
- `result_count`, out, CW: captured count.
- `timeout`, out, 1: the last run aborted on the watchdog.
- `run_count`, out, 8: number of successful runs; wraps 255→0.
- `mismatch`, out, 1: captured count ≠ `EXPECT_COUNT` (check build only).

## Operation
- States: IDLE, CLEAR, LAUNCH, WAIT.
- Edge detect: `go_q` registers `go`. A go edge is `go`=1 and `go_q`=0. `go_q` resets to 1, so a `go` held high through reset does not launch a run.
- IDLE:
  - On a go edge → CLEAR.
  - Clear `result_valid`, `timeout` and `mismatch`, and load the clear counter with 0.
  - Go edges seen in any other state are ignored and discarded.
- CLEAR:
  - `ctrl_clear`=1. The clear counter increments each cycle.
  - After `CLEAR_CYCLES` cycles → LAUNCH.
- LAUNCH:
  - `start`=1 for exactly one cycle → WAIT, with the watchdog loaded to 0.
- WAIT:
  - Priority 1: `done`=1 → capture `result_count`←`clock_count`, set `result_valid`=1, increment `run_count` (mod 256), → IDLE.
  - Priority 2: watchdog = `TIMEOUT`−1 and `done`=0 → set `timeout`=1, keep `result_valid`=0, → IDLE. `ctrl_clear` is pulsed one cycle on this transition.
  - Otherwise the watchdog increments.
- `done`=1 in the same cycle as the watchdog limit counts as success, not timeout.
- `done` seen in IDLE, CLEAR or LAUNCH is ignored; CLEAR guarantees it drops.
- `result_count` holds its value until the next successful capture. `result_valid` drops on the next accepted go edge.
- Reset: all outputs go to 0 immediately and asynchronously; state → IDLE; the watchdog and counters go to 0.
- Reset mid-run abandons the run with no capture. The controller is re-cleared by the next run's CLEAR.

## Timing
- Go edge sampled at edge E:
  - CLEAR spans cycles E+1..E+`CLEAR_CYCLES`.
  - `start` is high in cycle E+`CLEAR_CYCLES`+1.
  - WAIT begins at E+`CLEAR_CYCLES`+2.
- Capture occurs on the first rising edge in WAIT where `done`=1. `result_valid`, `result_count` and `run_count` update on that edge and are visible the next cycle. `busy` drops the same cycle.
- Timeout asserts `TIMEOUT` cycles after WAIT entry.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `RUN_LAUNCHER_CHECK_EN` defined:
  - On capture, `mismatch` is registered as (`clock_count` ≠ `EXPECT_COUNT`) and held until the next accepted go edge.
  - A mismatched run still increments `run_count`.
- `RUN_LAUNCHER_CHECK_EN` undefined: `mismatch` is tied to 0 and the comparator is not built.

## Test plan
- Nominal run: reset, then go 0→1 with the real controller (done after count 74) → `ctrl_clear` high 2 cycles, `start` high 1 cycle, then `result_valid`=1, `result_count`=74, `run_count`=1, `timeout`=0.
- Watchdog abort: `TIMEOUT`=100, `done` stuck 0 → `timeout`=1 exactly 100 cycles after WAIT entry, `ctrl_clear` pulse, `result_valid`=0, `run_count` unchanged.
- Tie case: `done` rises in the cycle the watchdog reaches `TIMEOUT`−1 → success capture, `timeout`=0.
- Go filtering:
  - `go` held high across reset release → no launch.
  - Second go edge during WAIT → ignored, exactly one run.
  - 256 successful runs → `run_count` wraps to 0.
- Async reset in WAIT at cycle 30 → all outputs 0 before the next clock edge, state IDLE; the next go gives a full nominal run with `result_count`=74.
- Check build: controller model returns 73 → `mismatch`=1, `result_count`=73. Without the macro, `mismatch` stays 0.
